// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed active-low segment bus,
// waits for each digit to be held steady for STABLE_CYCLES samples, then
// decodes the segment pattern back into a hex nibble for that digit position.
module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic [6:0]              HEX,
    input  logic [NUM_DIGITS-1:0]   ANODE,
    input  logic                    CLR_ERR,
    output logic [4*NUM_DIGITS-1:0] BIN,
    output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
    output logic                    UPDATE,
    output logic [1:0]              ERR
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [6:0]            prev_hex;
    logic [NUM_DIGITS-1:0] prev_anode;
    logic [NUM_DIGITS-1:0] anode_low;
    logic                  single;
    logic                  multi;
    logic                  changed;
    logic                  capture;
    logic                  dec_legal;
    logic                  dec_blank;
    logic [3:0]            dec_value;

    // An idle bus (no anode low) is neither single nor an error.
    assign anode_low = ~ANODE;
    assign single    = $onehot(anode_low);
    assign multi     = (|anode_low) && !single;
    assign changed   = (HEX != prev_hex) || (ANODE != prev_anode);

    // Segment pattern to nibble lookup (bit6=g ... bit0=a, active-low).
    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_value = 4'h0;
        case (HEX)
            7'b1000000: dec_value = 4'h0;
            7'b1111001: dec_value = 4'h1;
            7'b0100100: dec_value = 4'h2;
            7'b0110000: dec_value = 4'h3;
            7'b0011001: dec_value = 4'h4;
            7'b0010010: dec_value = 4'h5;
            7'b0000010: dec_value = 4'h6;
            7'b1111000: dec_value = 4'h7;
            7'b0000000: dec_value = 4'h8;
            7'b0010000: dec_value = 4'h9;
            7'b0001000: dec_value = 4'hA;
            7'b0000011: dec_value = 4'hB;
            7'b1000110: dec_value = 4'hC;
            7'b0100001: dec_value = 4'hD;
            7'b0000110: dec_value = 4'hE;
            7'b0001110: dec_value = 4'hF;
            7'b1111111: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_legal = 1'b0;
        endcase
    end

    // Stability tracker state register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: any change restarts the run at 1, identical samples count up
    // and saturate at the threshold, a non-single bus drops back to IDLE.
    always_comb begin
        cnt_next   = '0;
        state_next = IDLE;
        if (single) begin
            if (changed) begin
                cnt_next = CNT_W'(1);
            end else if (cnt < CNT_MAX) begin
                cnt_next = cnt + CNT_W'(1);
            end else begin
                cnt_next = cnt;
            end
            state_next = (cnt_next == CNT_MAX) ? HELD : TRACK;
        end
    end

    // Capture exactly once when a run first reaches the threshold; a changed
    // sample while already HELD only matters when the threshold is one.
    always_comb begin
        capture = (state_next == HELD) && ((state != HELD) || changed);
    end

    // Digit registers, update pulse, sticky errors and previous-sample history.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            BIN         <= '0;
            DIGIT_VALID <= '0;
            UPDATE      <= 1'b0;
            ERR         <= 2'b00;
            prev_hex    <= 7'h7F;
            prev_anode  <= '1;
        end else begin
            prev_hex   <= HEX;
            prev_anode <= ANODE;
            UPDATE     <= capture;
            ERR[0]     <= (capture && !dec_legal && !dec_blank) || (ERR[0] && !CLR_ERR);
            ERR[1]     <= multi || (ERR[1] && !CLR_ERR);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && anode_low[i]) begin
                    if (dec_legal) begin
                        BIN[4*i +: 4]  <= dec_value;
                        DIGIT_VALID[i] <= 1'b1;
                    end else begin
                        DIGIT_VALID[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: directed scenarios plus random
// scan traffic, all compared against a run-length based reference model.
module tb_sseg_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [6:0]  hex;
    logic [3:0]  anode;
    logic        clr_err;
    logic [15:0] bin;
    logic [3:0]  digit_valid;
    logic        update;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [6:0]  seg_table [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [15:0] m_bin;
    logic [3:0]  m_valid;
    logic        m_update;
    logic [1:0]  m_err;
    int          m_run;
    logic [6:0]  m_last_hex;
    logic [3:0]  m_last_anode;

    sseg_scan_decoder #(
        .NUM_DIGITS(NUM_DIGITS),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .CLOCK(clock),
        .RESET_N(reset_n),
        .HEX(hex),
        .ANODE(anode),
        .CLR_ERR(clr_err),
        .BIN(bin),
        .DIGIT_VALID(digit_valid),
        .UPDATE(update),
        .ERR(err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_bin        = '0;
        m_valid      = '0;
        m_update     = 1'b0;
        m_err        = 2'b00;
        m_run        = 0;
        m_last_hex   = 7'h7F;
        m_last_anode = 4'hF;
    endtask

    // One clock edge of the reference: count the length of the current run of
    // identical single-digit samples and capture when it first reaches the threshold.
    task automatic model_step();
        int  nlow;
        int  idx;
        int  val;
        bit  cap;
        nlow = $countones(~anode);
        cap  = 1'b0;
        if (nlow == 1) begin
            if (hex == m_last_hex && anode == m_last_anode) m_run++;
            else m_run = 1;
            cap = (m_run == STABLE_CYCLES);
        end else begin
            m_run = 0;
        end
        m_last_hex   = hex;
        m_last_anode = anode;
        if (clr_err) m_err = 2'b00;
        if (nlow >= 2) m_err[1] = 1'b1;
        m_update = cap;
        if (cap) begin
            idx = 0;
            for (int i = 0; i < NUM_DIGITS; i++) if (!anode[i]) idx = i;
            val = -1;
            for (int v = 0; v < 16; v++) if (seg_table[v] == hex) val = v;
            if (val >= 0) begin
                m_bin[idx*4 +: 4] = val[3:0];
                m_valid[idx]      = 1'b1;
            end else begin
                m_valid[idx] = 1'b0;
                if (hex != 7'h7F) m_err[0] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        hex     = 7'h7F;
        anode   = 4'hF;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bin !== 16'h0) begin errors++; $display("FAIL reset_bin got %h want 0000", bin); end
        checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %b want 0000", digit_valid); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", update); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", err); end
    endtask

    task automatic test_single_capture();
        int pulses = 0;
        hex   = 7'b0100100;
        anode = 4'b1110;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (update) pulses++;
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                errors++;
                $display("FAIL single_cycle%0d got bin=%h dv=%b upd=%b err=%b want bin=%h dv=%b upd=%b err=%b",
                         c, bin, digit_valid, update, err, m_bin, m_valid, m_update, m_err);
            end
            if (c == 3) begin
                checks++; if (update !== 1'b0) begin errors++; $display("FAIL single_early got upd=%b want 0", update); end
            end
            if (c == 4) begin
                checks++;
                if (bin[3:0] !== 4'h2 || digit_valid !== 4'b0001 || update !== 1'b1) begin
                    errors++;
                    $display("FAIL single_capture got bin0=%h dv=%b upd=%b want 2 0001 1", bin[3:0], digit_valid, update);
                end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_scan();
        logic [6:0] codes [4];
        int pulses = 0;
        codes[0] = seg_table[1];
        codes[1] = seg_table[10];
        codes[2] = seg_table[15];
        codes[3] = seg_table[8];
        for (int d = 0; d < 4; d++) begin
            hex   = codes[d];
            anode = ~(4'(1) << d);
            for (int c = 0; c < 6; c++) begin
                tick();
                if (update) pulses++;
                checks++;
                if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                    errors++;
                    $display("FAIL scan_d%0d_c%0d got bin=%h dv=%b upd=%b err=%b want bin=%h dv=%b upd=%b err=%b",
                             d, c, bin, digit_valid, update, err, m_bin, m_valid, m_update, m_err);
                end
            end
        end
        checks++; if (bin !== 16'h8FA1) begin errors++; $display("FAIL scan_bin got %h want 8fa1", bin); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid got %b want 1111", digit_valid); end
        checks++; if (pulses != 4) begin errors++; $display("FAIL scan_pulses got %0d want 4", pulses); end
    endtask

    task automatic test_unstable();
        int pulses = 0;
        int total;
        logic [6:0] seq_hex [4];
        logic [3:0] seq_anode [4];
        int         seq_len [4];
        apply_reset();
        anode = 4'b1110;
        for (int c = 0; c < 12; c++) begin
            hex = ((c / 2) % 2 == 0) ? seg_table[1] : seg_table[2];
            tick();
            if (update) pulses++;
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err} || bin !== 16'h0) begin
                errors++;
                $display("FAIL toggle_c%0d got bin=%h upd=%b want bin=%h upd=%b", c, bin, update, m_bin, m_update);
            end
        end
        seq_hex[0] = seg_table[1]; seq_anode[0] = 4'b1110; seq_len[0] = 3;
        seq_hex[1] = seg_table[2]; seq_anode[1] = 4'b1110; seq_len[1] = 4;
        seq_hex[2] = seg_table[5]; seq_anode[2] = 4'b1110; seq_len[2] = 3;
        seq_hex[3] = seg_table[5]; seq_anode[3] = 4'b1101; seq_len[3] = 4;
        for (int p = 0; p < 4; p++) begin
            hex   = seq_hex[p];
            anode = seq_anode[p];
            for (int c = 0; c < seq_len[p]; c++) begin
                tick();
                if (update) pulses++;
                checks++;
                if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                    errors++;
                    $display("FAIL unstable_p%0d_c%0d got bin=%h dv=%b upd=%b want bin=%h dv=%b upd=%b",
                             p, c, bin, digit_valid, update, m_bin, m_valid, m_update);
                end
            end
            if (p == 0) begin
                checks++; if (pulses != 0 || bin !== 16'h0) begin errors++; $display("FAIL short_run got pulses=%0d bin=%h want 0 0000", pulses, bin); end
            end
        end
        total = pulses;
        checks++; if (total != 2) begin errors++; $display("FAIL unstable_pulses got %0d want 2", total); end
        checks++; if (bin !== 16'h0052) begin errors++; $display("FAIL unstable_bin got %h want 0052", bin); end
    endtask

    task automatic test_illegal();
        hex   = 7'b1010101;
        anode = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                errors++;
                $display("FAIL illegal_c%0d got bin=%h dv=%b err=%b want bin=%h dv=%b err=%b",
                         c, bin, digit_valid, err, m_bin, m_valid, m_err);
            end
        end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL illegal_err got %b want 01", err); end
        checks++; if (digit_valid[1] !== 1'b0 || bin[7:4] !== 4'h5) begin errors++; $display("FAIL illegal_digit got dv1=%b bin1=%h want 0 5", digit_valid[1], bin[7:4]); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (err !== 2'b00 || m_err !== 2'b00) begin errors++; $display("FAIL clear_err got %b want 00", err); end
    endtask

    task automatic test_blank();
        hex   = seg_table[7];
        anode = 4'b1110;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) hex = 7'h7F;
            tick();
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                errors++;
                $display("FAIL blank_c%0d got bin=%h dv=%b upd=%b err=%b want bin=%h dv=%b upd=%b err=%b",
                         c, bin, digit_valid, update, err, m_bin, m_valid, m_update, m_err);
            end
            if (c == 4) begin
                checks++; if (bin[3:0] !== 4'h7 || digit_valid[0] !== 1'b1) begin errors++; $display("FAIL seven_capture got bin0=%h dv0=%b want 7 1", bin[3:0], digit_valid[0]); end
            end
        end
        checks++;
        if (digit_valid[0] !== 1'b0 || bin[3:0] !== 4'h7 || err !== 2'b00) begin
            errors++;
            $display("FAIL blank_result got dv0=%b bin0=%h err=%b want 0 7 00", digit_valid[0], bin[3:0], err);
        end
    endtask

    task automatic test_multi_anode();
        int pulses = 0;
        hex   = seg_table[3];
        anode = 4'b1100;
        tick();
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL multi_err got %b want 10", err); end
        anode = 4'b1110;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (update) pulses++;
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                errors++;
                $display("FAIL multi_restart_c%0d got bin=%h upd=%b want bin=%h upd=%b", c, bin, update, m_bin, m_update);
            end
        end
        checks++; if (pulses != 1 || update !== 1'b1 || bin[3:0] !== 4'h3) begin errors++; $display("FAIL multi_restart got pulses=%0d upd=%b bin0=%h want 1 1 3", pulses, update, bin[3:0]); end
        anode   = 4'b0110;
        clr_err = 1'b1;
        tick();
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL set_wins got %b want 10", err); end
        anode = 4'hF;
        tick();
        clr_err = 1'b0;
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL idle_clear got %b want 00", err); end
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        hex   = seg_table[3];
        anode = 4'b1011;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bin, digit_valid, update, err} !== 23'h0) begin
            errors++;
            $display("FAIL async_reset got bin=%h dv=%b upd=%b err=%b want all zero", bin, digit_valid, update, err);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (update) pulses++;
            checks++;
            if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                errors++;
                $display("FAIL post_reset_c%0d got bin=%h dv=%b upd=%b want bin=%h dv=%b upd=%b",
                         c, bin, digit_valid, update, m_bin, m_valid, m_update);
            end
            if (c == 3) begin
                checks++; if (pulses != 0) begin errors++; $display("FAIL post_reset_early got pulses=%0d want 0", pulses); end
            end
        end
        checks++; if (pulses != 1 || bin !== 16'h0300) begin errors++; $display("FAIL post_reset got pulses=%0d bin=%h want 1 0300", pulses, bin); end
    endtask

    task automatic test_random();
        int cyc = 0;
        int hold;
        int pick;
        while (cyc < 600) begin
            pick = $urandom_range(99, 0);
            if (pick < 70)      hex = seg_table[$urandom_range(15, 0)];
            else if (pick < 80) hex = 7'h7F;
            else                hex = 7'($urandom);
            pick = $urandom_range(99, 0);
            if (pick < 80)      anode = ~(4'(1) << $urandom_range(3, 0));
            else if (pick < 90) anode = 4'hF;
            else                anode = 4'($urandom);
            hold = $urandom_range(6, 1);
            for (int c = 0; c < hold; c++) begin
                clr_err = ($urandom_range(15, 0) == 0);
                tick();
                cyc++;
                checks++;
                if ({bin, digit_valid, update, err} !== {m_bin, m_valid, m_update, m_err}) begin
                    errors++;
                    $display("FAIL random_cyc%0d got bin=%h dv=%b upd=%b err=%b want bin=%h dv=%b upd=%b err=%b",
                             cyc, bin, digit_valid, update, err, m_bin, m_valid, m_update, m_err);
                end
            end
        end
        clr_err = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        hex     = 7'h7F;
        anode   = 4'hF;
        clr_err = 1'b0;
        model_reset();
        test_reset();
        test_single_capture();
        test_scan();
        test_unstable();
        test_illegal();
        test_blank();
        test_multi_anode();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Monitors a multiplexed, active-low seven-segment display bus: segment lines HEX plus active-low digit selects ANODE.
- Reconstructs the 4-bit hex value shown on each digit position.
- Inverse of the team's binary-to-segment encoder. Used on-chip as a display readback checker and as a bench-side scoreboard front end.
- Debounces scan transitions by requiring STABLE_CYCLES identical consecutive samples before it accepts a digit.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions; must be ≥1.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; must be ≥1.
- CNT_W, 4, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- HEX  input  7  segment lines, active-low. bit0=a … bit6=g.
- ANODE  input  NUM_DIGITS  digit selects, active-low. bit i = digit i.
- CLR_ERR  input  1  synchronous clear of the ERR bits.
- BIN  output  4*NUM_DIGITS  decoded values. Digit i is BIN[4i+3:4i].
- DIGIT_VALID  output  NUM_DIGITS  bit i=1 when digit i last captured a legal code.
- UPDATE  output  1  one-cycle pulse on any capture.
- ERR  output  2  sticky flags. [0] illegal segment code. [1] multiple anodes active.

Behaviour:
- Clock and reset: single CLOCK domain. HEX, ANODE and CLR_ERR are synchronous to CLOCK; this block contains no synchronizers.
- Reset (async assert, sync release): BIN=0, DIGIT_VALID=0, UPDATE=0, ERR=0, cnt=0, prev_hex=7'h7F, prev_anode=all ones, state=IDLE.
- "Single" means exactly one ANODE bit is low.
- Decode table (HEX -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - 1111111 = blank.
  - Any other pattern = illegal.
- Stability counter update, every rising edge:
  - Not single: cnt<=0, state<=IDLE.
  - Single and {HEX,ANODE} differs from {prev_hex,prev_anode}: cnt<=1, state<=TRACK.
  - Single and identical: cnt<=min(cnt+1, STABLE_CYCLES).
  - prev_hex and prev_anode are loaded with the inputs every edge.
- Capture: happens on the edge where cnt transitions to STABLE_CYCLES (TRACK->HELD).
  - Exactly one capture per stable run. HELD holds with no recapture until the inputs change.
  - With STABLE_CYCLES=1, capture happens on the first single edge.
- Capture effects on digit i (the low ANODE bit):
  - Legal code: BIN digit i <= value, DIGIT_VALID[i] <= 1.
  - Blank: BIN digit i unchanged, DIGIT_VALID[i] <= 0, no error.
  - Illegal: BIN digit i unchanged, DIGIT_VALID[i] <= 0, ERR[0] <= 1.
  - UPDATE=1 for the cycle after any capture edge (legal, blank or illegal), else 0.
  - All other digits are untouched.
- Latency: inputs steady before edge 1 give updated outputs after edge STABLE_CYCLES. Default: visible after edge 4.
- ERR[1] is set on any edge where two or more ANODE bits are low. All-high ANODE is idle and not an error.
- ERR is sticky until CLR_ERR=1 at an edge. If set and clear coincide at the same edge, set wins.
- An anode change with identical HEX counts as a change and restarts at cnt=1.
- A change on the same edge that would have captured restarts at cnt=1; no capture occurs.
- Reset mid-run discards the run, and all outputs return to their reset values immediately.

Test Plan:
- Reset, then HEX=0100100 with ANODE=1110 held for 4 edges -> after edge 4, BIN[3:0]=2, DIGIT_VALID=0001, UPDATE high for exactly 1 cycle; holding the inputs 10 more cycles gives no further UPDATE.
- Scan digits 0..3 with codes 1,A,F,8, each held 6 cycles -> BIN=16'h8FA1, DIGIT_VALID=1111, 4 UPDATE pulses.
- Hold ANODE=1110 with HEX toggling between 1111001 and 0100100 every 2 cycles -> no capture, BIN and UPDATE stay 0. Then hold 3 cycles only -> still no capture; hold 4 -> capture.
- HEX=1010101 on ANODE=1101 for 4 cycles -> ERR=01, DIGIT_VALID[1]=0, BIN[7:4] unchanged. Then assert CLR_ERR for 1 cycle -> ERR=00.
- After digit 0 is captured as 7, drive HEX=1111111 for 4 cycles -> DIGIT_VALID[0]=0, BIN[3:0] stays 7, ERR=00.
- ANODE=1100 for 1 cycle -> ERR[1]=1 and cnt=0. Assert RESET_N low at cycle 2 of a TRACK run -> all outputs 0, and no capture follows release until a fresh 4-cycle stable run.
